// File: rtl/konark_tohost_mailbox.sv
// konark_tohost_mailbox: HTIF tohost/fromhost mailbox with exit decode and end-of-computation flag
module konark_tohost_mailbox #(
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned ExitCodeWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    input  logic [3:0]               addr_i,
    input  logic                     we_i,
    input  logic [DataWidth-1:0]     wdata_i,
    input  logic [DataWidth/8-1:0]   be_i,
    output logic                     gnt_o,
    output logic                     rvalid_o,
    output logic [DataWidth-1:0]     rdata_o,
    output logic                     host_valid_o,
    input  logic                     host_ready_i,
    output logic [DataWidth-1:0]     host_data_o,
    input  logic                     fromhost_valid_i,
    input  logic [DataWidth-1:0]     fromhost_data_i,
    output logic                     eoc_o,
    output logic [ExitCodeWidth-1:0] exit_code_o
);
    typedef enum logic [1:0] {IDLE, PENDING, EXITED} state_e;
    state_e                   state_q;
    logic [DataWidth-1:0]     tohost_q, tohost_d, fromhost_q, fromhost_d, rdata_q, rdata_d, wmask;
    logic [ExitCodeWidth-1:0] exit_q;
    logic                     rvalid_q, sel_to, sel_from, wr_to, wr_from, hs;
    assign sel_to       = addr_i == 4'h0;
    assign sel_from     = addr_i == 4'h8;
    // the stall looks only at registered state, so host_ready_i never reaches gnt_o
    assign gnt_o        = req_i && !(we_i && sel_to && state_q == PENDING);
    assign wr_to        = gnt_o && we_i && sel_to;
    assign wr_from      = gnt_o && we_i && sel_from;
    assign hs           = state_q == PENDING && host_ready_i;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign host_valid_o = state_q == PENDING;
    assign host_data_o  = tohost_q;
    assign eoc_o        = state_q == EXITED;
    assign exit_code_o  = exit_q;
    // byte-merge next values; host strobe beats a target write to fromhost
    always_comb begin
        wmask = '0;
        for (int i = 0; i < DataWidth/8; i++) wmask[8*i +: 8] = {8{be_i[i]}};
        tohost_d   = hs ? '0 : (wr_to && state_q == IDLE) ? ((tohost_q & ~wmask) | (wdata_i & wmask)) : tohost_q;
        fromhost_d = fromhost_valid_i ? fromhost_data_i : wr_from ? ((fromhost_q & ~wmask) | (wdata_i & wmask)) : fromhost_q;
        rdata_d    = sel_to ? tohost_q : sel_from ? fromhost_q : '0;
    end
    // mailbox FSM with registered response, data and exit code
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tohost_q   <= '0;
            fromhost_q <= '0;
            exit_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            tohost_q   <= tohost_d;
            fromhost_q <= fromhost_d;
            rvalid_q   <= gnt_o;
            rdata_q    <= rdata_d;
            case (state_q)
                IDLE:    if (wr_to && be_i[0]) state_q <= PENDING;
                PENDING: if (host_ready_i) begin
                    state_q <= tohost_q[0] ? EXITED : IDLE;
                    if (tohost_q[0]) exit_q <= tohost_q[ExitCodeWidth:1];
                end
                default: state_q <= EXITED;
            endcase
        end
    end
endmodule

// File: tb/tb_konark_tohost_mailbox.sv
// tb_konark_tohost_mailbox: directed checks of the tohost/fromhost mailbox
module tb_konark_tohost_mailbox;
    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, gnt, rvalid;
    logic [3:0]  addr = '0;
    logic [63:0] wdata = '0, rdata, host_data, fh_data = '0;
    logic [7:0]  be = '0;
    logic        host_valid, host_ready = 1'b0, fh_valid = 1'b0, eoc;
    logic [31:0] exit_code;
    logic        g, rv;
    logic [63:0] rd;
    int          pass_cnt = 0, total = 0;

    konark_tohost_mailbox dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .host_valid_o(host_valid), .host_ready_i(host_ready),
        .host_data_o(host_data), .fromhost_valid_i(fh_valid), .fromhost_data_i(fh_data), .eoc_o(eoc), .exit_code_o(exit_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        host_ready = 1'b0;
        fh_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // one single-cycle bus attempt: grant sampled before the edge, response after it
    task automatic cyc(input logic w, input logic [3:0] a, input logic [63:0] d, input logic [7:0] b,
                       output logic go, output logic rvo, output logic [63:0] rdo);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1 go = gnt;
        tick();
        req = 1'b0; we = 1'b0;
        rvo = rvalid;
        rdo = rdata;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({host_valid, eoc, rvalid} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {host_valid, eoc, rvalid}); else pass_cnt++;
        total++; if (exit_code !== 32'h0) $display("FAIL reset_exit_code: got %h exp 0", exit_code); else pass_cnt++;
        total++; if (gnt !== 1'b0) $display("FAIL reset_gnt_idle: got %b exp 0", gnt); else pass_cnt++;
        cyc(1'b0, 4'h0, '0, 8'h00, g, rv, rd);
        total++; if ({g, rv, rd} !== {2'b11, 64'h0}) $display("FAIL reset_read_tohost: got %b%b %h exp 11 0", g, rv, rd); else pass_cnt++;
        cyc(1'b0, 4'h8, '0, 8'h00, g, rv, rd);
        total++; if (rd !== 64'h0) $display("FAIL reset_read_fromhost: got %h exp 0", rd); else pass_cnt++;
    endtask

    task automatic test_exit_success();
        do_reset();
        cyc(1'b1, 4'h0, 64'h1, 8'hFF, g, rv, rd);
        total++; if ({g, rv, host_valid} !== 3'b111) $display("FAIL es_write: got %b exp 111", {g, rv, host_valid}); else pass_cnt++;
        total++; if (host_data !== 64'h1) $display("FAIL es_host_data: got %h exp 1", host_data); else pass_cnt++;
        tick();
        tick();
        total++; if ({host_valid, host_data} !== {1'b1, 64'h1}) $display("FAIL es_stable: got %b %h exp 1 1", host_valid, host_data); else pass_cnt++;
        host_ready = 1'b1;
        tick();
        host_ready = 1'b0;
        total++; if ({host_valid, eoc, exit_code} !== {2'b01, 32'h0}) $display("FAIL es_exit: got %b%b %h exp 01 0", host_valid, eoc, exit_code); else pass_cnt++;
    endtask

    task automatic test_exit_failure();
        do_reset();
        cyc(1'b1, 4'h0, 64'h7, 8'hFF, g, rv, rd);
        host_ready = 1'b1;
        tick();
        host_ready = 1'b0;
        total++; if ({eoc, exit_code} !== {1'b1, 32'h3}) $display("FAIL ef_exit: got %b %h exp 1 3", eoc, exit_code); else pass_cnt++;
        cyc(1'b1, 4'h0, 64'h9, 8'hFF, g, rv, rd);
        tick();
        total++; if ({g, host_valid, eoc, exit_code} !== {3'b101, 32'h3}) $display("FAIL ef_dropped: got %b%b%b %h exp 101 3", g, host_valid, eoc, exit_code); else pass_cnt++;
    endtask

    task automatic test_syscall();
        int stalls = 0;
        do_reset();
        cyc(1'b1, 4'h0, 64'h8000_1000, 8'hFF, g, rv, rd);
        req = 1'b1; we = 1'b1; addr = 4'h0; wdata = 64'h2; be = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            #1 if (gnt === 1'b0) stalls++;
            tick();
        end
        total++; if (stalls !== 10) $display("FAIL sc_stall: got %0d exp 10", stalls); else pass_cnt++;
        host_ready = 1'b1;
        #1;
        total++; if (gnt !== 1'b0) $display("FAIL sc_no_ready_path: got %b exp 0", gnt); else pass_cnt++;
        tick();
        host_ready = 1'b0;
        #1;
        total++; if ({host_valid, gnt} !== 2'b01) $display("FAIL sc_after_hs: got %b exp 01", {host_valid, gnt}); else pass_cnt++;
        tick();
        req = 1'b0; we = 1'b0;
        total++; if ({host_valid, host_data} !== {1'b1, 64'h2}) $display("FAIL sc_stalled_write: got %b %h exp 1 2", host_valid, host_data); else pass_cnt++;
        host_ready = 1'b1;
        cyc(1'b0, 4'h0, '0, 8'h00, g, rv, rd);
        host_ready = 1'b0;
        total++; if ({host_valid, rd} !== {1'b0, 64'h2}) $display("FAIL sc_read_hs_cycle: got %b %h exp 0 2", host_valid, rd); else pass_cnt++;
        cyc(1'b0, 4'h0, '0, 8'h00, g, rv, rd);
        total++; if (rd !== 64'h0) $display("FAIL sc_read_cleared: got %h exp 0", rd); else pass_cnt++;
        fh_valid = 1'b1; fh_data = 64'h1;
        tick();
        fh_valid = 1'b0;
        cyc(1'b0, 4'h8, '0, 8'h00, g, rv, rd);
        total++; if (rd !== 64'h1) $display("FAIL sc_fromhost: got %h exp 1", rd); else pass_cnt++;
        cyc(1'b1, 4'h8, 64'h0, 8'hFF, g, rv, rd);
        cyc(1'b0, 4'h8, '0, 8'h00, g, rv, rd);
        total++; if (rd !== 64'h0) $display("FAIL sc_fromhost_clear: got %h exp 0", rd); else pass_cnt++;
    endtask

    task automatic test_partial();
        do_reset();
        cyc(1'b1, 4'h0, 64'hAABB_0000, 8'hFC, g, rv, rd);
        total++; if (host_valid !== 1'b0) $display("FAIL pw_no_valid: got %b exp 0", host_valid); else pass_cnt++;
        cyc(1'b0, 4'h0, '0, 8'h00, g, rv, rd);
        total++; if (rd !== 64'hAABB_0000) $display("FAIL pw_merge: got %h exp aabb0000", rd); else pass_cnt++;
        cyc(1'b1, 4'h0, 64'h1, 8'h01, g, rv, rd);
        total++; if ({host_valid, host_data} !== {1'b1, 64'hAABB_0001}) $display("FAIL pw_host_data: got %b %h exp 1 aabb0001", host_valid, host_data); else pass_cnt++;
        host_ready = 1'b1;
        tick();
        host_ready = 1'b0;
        total++; if ({eoc, exit_code} !== {1'b1, 32'h555D_8000}) $display("FAIL pw_exit_code: got %b %h exp 1 555d8000", eoc, exit_code); else pass_cnt++;
    endtask

    task automatic test_collision();
        do_reset();
        fh_valid = 1'b1; fh_data = 64'h5;
        cyc(1'b1, 4'h8, 64'h2, 8'hFF, g, rv, rd);
        fh_valid = 1'b0;
        cyc(1'b0, 4'h8, '0, 8'h00, g, rv, rd);
        total++; if (rd !== 64'h5) $display("FAIL collision: got %h exp 5", rd); else pass_cnt++;
    endtask

    task automatic test_other_offset();
        do_reset();
        cyc(1'b1, 4'h4, 64'hFF, 8'hFF, g, rv, rd);
        cyc(1'b0, 4'h4, '0, 8'h00, g, rv, rd);
        total++; if ({g, rv, rd, host_valid} !== {2'b11, 64'h0, 1'b0}) $display("FAIL other_offset: got %b%b %h %b exp 11 0 0", g, rv, rd, host_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1'b1, 4'h0, 64'h3, 8'hFF, g, rv, rd);
        total++; if (host_valid !== 1'b1) $display("FAIL rm_pending: got %b exp 1", host_valid); else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if ({host_valid, eoc} !== 2'b00) $display("FAIL rm_flags: got %b exp 00", {host_valid, eoc}); else pass_cnt++;
        cyc(1'b0, 4'h0, '0, 8'h00, g, rv, rd);
        total++; if ({rd, eoc} !== {64'h0, 1'b0}) $display("FAIL rm_read: got %h %b exp 0 0", rd, eoc); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_exit_success();
        test_exit_failure();
        test_syscall();
        test_partial();
        test_collision();
        test_other_offset();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
